// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer, plus flush and stall.
// Define PIPE_STAGE_PERF_EN to add the saturating stall-cycle counter on stall_cnt_o.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

  logic              main_v_q, main_v_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_v_q, skid_v_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic in_fire;
  logic out_fire;

  // ready_o depends only on stored state, breaking the ready_i -> ready_o path
  assign ready_o  = !skid_v_q;
  assign in_fire  = valid_i && ready_o;
  assign out_fire = main_v_q && ready_i && !stall_i;

  assign valid_o = main_v_q;
  assign ctrl_o  = main_v_q ? main_ctrl_q : '0;
  assign data_o  = main_data_q;

  always_comb begin
    main_v_d    = main_v_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      main_v_d    = 1'b0;
      skid_v_d    = 1'b0;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else if (!main_v_q || out_fire) begin
      if (skid_v_q) begin
        main_v_d    = 1'b1;
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
      end else begin
        main_v_d = in_fire;
        if (in_fire) begin
          main_ctrl_d = ctrl_i;
          main_data_d = data_i;
        end
      end
    end else if (in_fire) begin
      skid_v_d    = 1'b1;
      skid_ctrl_d = ctrl_i;
      skid_data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_v_q    <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_v_q    <= 1'b0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_v_q    <= skid_v_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_v_q && !out_fire && !flush_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: entries are queued when accepted and compared when delivered.
// Define PIPE_STAGE_PERF_EN to also exercise the stall-cycle counter.
module tb_pipe_stage_skid;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned DATA_W = 69;
  localparam int unsigned CNT_W  = 2;

  typedef logic [CTRL_W+DATA_W-1:0] entry_t;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt_o;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned occ    = 0;
  entry_t      sb[$];

  pipe_stage_skid #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .stall_i(stall_i),
    .flush_i(flush_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .ctrl_i (ctrl_i),
    .data_i (data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .ctrl_o (ctrl_o),
    .data_o (data_o)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input int unsigned d,
                       input logic r, input logic s, input logic f);
    valid_i = v;
    ctrl_i  = c;
    data_i  = DATA_W'(d);
    ready_i = r;
    stall_i = s;
    flush_i = f;
  endtask

  // Reference occupancy model: ready whenever fewer than two entries are held.
  task automatic tick();
    bit inf;
    bit outf;
    inf  = valid_i && (occ < 2);
    outf = (occ > 0) && ready_i && !stall_i;
    @(posedge clk_i);
    if (flush_i) begin
      occ = 0;
      sb.delete();
    end else begin
      if (inf) sb.push_back({ctrl_i, data_i});
      occ = occ + (inf ? 1 : 0) - (outf ? 1 : 0);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    drive(1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
    #3;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || ctrl_o !== '0 || data_o !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%b c=%h d=%h exp v=0 r=1 c=0 d=0",
               valid_o, ready_o, ctrl_o, data_o);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (stall_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_cnt got %0d exp 0", stall_cnt_o);
    end
`endif
    #5 rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_streaming();
    entry_t exp;
    for (int unsigned i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, 4'hF, i + 1, 1'b1, 1'b0, 1'b0);
      else       drive(1'b0, 4'h0, 0,     1'b1, 1'b0, 1'b0);
      checks++;
      if (ready_o !== 1'b1 || valid_o !== (occ > 0)) begin
        errors++;
        $display("FAIL stream_hs cyc %0d got r=%b v=%b exp r=1 v=%b", i, ready_o, valid_o, occ > 0);
      end
      if (occ > 0) begin
        exp = sb.pop_front();
        checks++;
        if ({ctrl_o, data_o} !== exp) begin
          errors++;
          $display("FAIL stream_data cyc %0d got %h/%h exp %h", i, ctrl_o, data_o, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic        rdy_tab[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int unsigned idx = 0;
    entry_t      exp;
    for (int unsigned i = 0; i < 8; i++) begin
      drive(idx < 3, 4'h3, 10 + idx, rdy_tab[i], 1'b0, 1'b0);
      checks++;
      if (ready_o !== (occ < 2) || valid_o !== (occ > 0)) begin
        errors++;
        $display("FAIL bp_hs cyc %0d got r=%b v=%b exp r=%b v=%b",
                 i, ready_o, valid_o, occ < 2, occ > 0);
      end
      if (occ > 0 && ready_i) begin
        exp = sb.pop_front();
        checks++;
        if ({ctrl_o, data_o} !== exp) begin
          errors++;
          $display("FAIL bp_data cyc %0d got %h/%h exp %h", i, ctrl_o, data_o, exp);
        end
      end
      if (valid_i && occ < 2) idx++;
      tick();
    end
    checks++;
    if (idx != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got accepted=%0d left=%0d exp accepted=3 left=0", idx, sb.size());
    end
  endtask

  task automatic test_stall_flush();
    entry_t exp;
    drive(1'b1, 4'hF, 'h55, 1'b1, 1'b0, 1'b0);
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b0, 4'h0, 0,    1'b1, 1'b1, 1'b0);
      else       drive(1'b1, 4'hF, 'h66, 1'b1, 1'b1, 1'b1);
      exp = {4'hF, DATA_W'('h55)};
      checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b1 || {ctrl_o, data_o} !== exp) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got v=%b r=%b %h/%h exp v=1 r=1 %h",
                 i, valid_o, ready_o, ctrl_o, data_o, exp);
      end
      tick();
    end
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b0, 4'h0, 0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (valid_o !== 1'b0 || ctrl_o !== '0 || ready_o !== 1'b1) begin
        errors++;
        $display("FAIL post_flush cyc %0d got v=%b c=%h r=%b d=%h exp v=0 c=0 r=1",
                 i, valid_o, ctrl_o, ready_o, data_o);
      end
      tick();
    end
  endtask

  task automatic test_bubble();
    logic        v_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int unsigned d_tab[5] = '{7, 'h99, 8, 0, 0};
    logic        ev_tab[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    entry_t      exp;
    for (int unsigned i = 0; i < 5; i++) begin
      drive(v_tab[i], (i == 2) ? 4'h5 : 4'hA, d_tab[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (valid_o !== ev_tab[i]) begin
        errors++;
        $display("FAIL bubble_valid cyc %0d got %b exp %b", i, valid_o, ev_tab[i]);
      end
      if (occ > 0) begin
        exp = sb.pop_front();
        checks++;
        if ({ctrl_o, data_o} !== exp) begin
          errors++;
          $display("FAIL bubble_data cyc %0d got %h/%h exp %h", i, ctrl_o, data_o, exp);
        end
      end else begin
        checks++;
        if (ctrl_o !== 4'h0) begin
          errors++;
          $display("FAIL bubble_ctrl cyc %0d got %h exp 0", i, ctrl_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 4'h3, 'h100, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'h6, 'h101, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_before_rst got v=%b r=%b exp v=1 r=0", valid_o, ready_o);
    end
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || ctrl_o !== '0 || data_o !== '0) begin
      errors++;
      $display("FAIL mid_reset got v=%b r=%b c=%h d=%h exp v=0 r=1 c=0 d=0",
               valid_o, ready_o, ctrl_o, data_o);
    end
    occ = 0;
    sb.delete();
    #1 rst_n_i = 1'b1;
    drive(1'b0, 4'h0, 0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL after_reset got v=%b r=%b exp v=0 r=1", valid_o, ready_o);
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    logic [CNT_W-1:0] exp_cnt[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    entry_t           exp;
    rst_n_i = 1'b0;
    #1 rst_n_i = 1'b1;
    occ = 0;
    sb.delete();
    for (int unsigned i = 0; i < 6; i++) begin
      if (i == 0) drive(1'b1, 4'h9, 'h42, 1'b0, 1'b0, 1'b0);
      else        drive(1'b0, 4'h0, 0,     1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (stall_cnt_o !== exp_cnt[i]) begin
        errors++;
        $display("FAIL perf_cnt cyc %0d got %0d exp %0d", i, stall_cnt_o, exp_cnt[i]);
      end
    end
    drive(1'b0, 4'h0, 0, 1'b1, 1'b0, 1'b0);
    exp = sb.pop_front();
    checks++;
    if ({ctrl_o, data_o} !== exp) begin
      errors++;
      $display("FAIL perf_data got %h/%h exp %h", ctrl_o, data_o, exp);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall_flush();
    test_bubble();
    test_reset_midflight();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
